mux_response_checker: RTL

MUX_RESPONSE_CHECKER -- requirements
Module: mux_response_checker

---
 rtl/mux_chk_pkg.sv | 24 ++
 rtl/mux_response_checker_if.sv | 45 ++++
 rtl/mux_chk_golden.sv | 16 +
 rtl/mux_response_checker.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mux_chk_pkg.sv
// Shared types and constants for the carry-select mux response checker.
package mux_chk_pkg;

   localparam int VEC_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_t;

   // Reference carry-select mux behaviour: returns {carry, sum}
   function automatic logic [1:0] mux_expect(input logic sel, input logic sum_1, input logic sum_2,
                                             input logic cout_1, input logic cout_2);
      logic [1:0] res;
      if (sel == 1'b1) begin
         res = {cout_2, sum_2};
      end else begin
         res = {cout_1, sum_1};
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_response_checker_if.sv
// Bus bundle between a vector source and the mux response checker.
// The fail-log signals exist only when CHK_FAIL_LOG_EN is defined.
interface mux_response_checker_if #(
   parameter int ERR_W = 8
);
   import mux_chk_pkg::*;

   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic             sum_1;
   logic             sum_2;
   logic             cout_1;
   logic             cout_2;
   logic             sel;
   logic             dut_sum;
   logic             dut_carry;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [VEC_W-1:0] vec_count;
`ifdef CHK_FAIL_LOG_EN
   logic             fail_valid;
   logic [VEC_W-1:0] fail_index;
   logic [6:0]       fail_data;
`endif

   modport master (
      output start, in_valid, sum_1, sum_2, cout_1, cout_2, sel, dut_sum, dut_carry,
`ifdef CHK_FAIL_LOG_EN
      input  fail_valid, fail_index, fail_data,
`endif
      input  in_ready, busy, done, pass, err_count, vec_count
   );

   modport slave (
      input  start, in_valid, sum_1, sum_2, cout_1, cout_2, sel, dut_sum, dut_carry,
`ifdef CHK_FAIL_LOG_EN
      output fail_valid, fail_index, fail_data,
`endif
      output in_ready, busy, done, pass, err_count, vec_count
   );

endinterface

// File: rtl/mux_chk_golden.sv
// Combinational expected-value model of the 1-bit carry-select mux.
module mux_chk_golden
   import mux_chk_pkg::*;
(
   input  logic sel_i,
   input  logic sum_1_i,
   input  logic sum_2_i,
   input  logic cout_1_i,
   input  logic cout_2_i,
   output logic exp_sum_o,
   output logic exp_carry_o
);

   assign {exp_carry_o, exp_sum_o} = mux_expect(sel_i, sum_1_i, sum_2_i, cout_1_i, cout_2_i);

endmodule

// File: rtl/mux_response_checker.sv
// Runs NUM_VECTORS vectors against a carry-select mux and counts mismatches.
// Optional first-failure log enabled by defining CHK_FAIL_LOG_EN.
module mux_response_checker
   import mux_chk_pkg::*;
#(
   parameter int NUM_VECTORS = 32,
   parameter int ERR_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mux_response_checker_if.slave  bus
);

   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS);

   chk_state_t       state_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [ERR_W-1:0] err_q;
   logic [ERR_W-1:0] err_d;
   logic [VEC_W-1:0] vec_q;
   logic [VEC_W-1:0] vec_d;
   logic             exp_sum_s;
   logic             exp_carry_s;
   logic             accept_s;
   logic             mismatch_s;
   logic             last_s;
   logic             start_run_s;

   mux_chk_golden u_golden (
      .sel_i       (bus.sel),
      .sum_1_i     (bus.sum_1),
      .sum_2_i     (bus.sum_2),
      .cout_1_i    (bus.cout_1),
      .cout_2_i    (bus.cout_2),
      .exp_sum_o   (exp_sum_s),
      .exp_carry_o (exp_carry_s)
   );

   // Acceptance, mismatch detection and saturating next-count values
   always_comb begin
      accept_s    = bus.in_valid & in_ready_q;
      mismatch_s  = (bus.dut_sum != exp_sum_s) | (bus.dut_carry != exp_carry_s);
      start_run_s = bus.start & (state_q != RUN);
      vec_d       = vec_q + 10'd1;
      last_s      = (vec_d == VEC_LAST);
      if (mismatch_s && (err_q != ERR_MAX)) begin
         err_d = err_q + ERR_ONE;
      end else begin
         err_d = err_q;
      end
   end

   // Run-control FSM with registered status outputs and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         vec_q      <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_q    <= RUN;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
                  err_q      <= '0;
                  vec_q      <= '0;
               end
            end
            RUN: begin
               if (accept_s) begin
                  vec_q <= vec_d;
                  err_q <= err_d;
                  if (last_s) begin
                     state_q    <= DONE;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     pass_q     <= (err_d == '0);
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               pass_q     <= 1'b0;
               err_q      <= '0;
               vec_q      <= '0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.vec_count = vec_q;

`ifdef CHK_FAIL_LOG_EN
   logic             fail_valid_q;
   logic [VEC_W-1:0] fail_index_q;
   logic [6:0]       fail_data_q;

   // Capture only the first mismatching vector of each run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_valid_q <= 1'b0;
         fail_index_q <= '0;
         fail_data_q  <= '0;
      end else if (start_run_s) begin
         fail_valid_q <= 1'b0;
         fail_index_q <= '0;
         fail_data_q  <= '0;
      end else if (accept_s && mismatch_s && !fail_valid_q) begin
         fail_valid_q <= 1'b1;
         fail_index_q <= vec_q;
         fail_data_q  <= {bus.sel, bus.sum_1, bus.sum_2, bus.cout_1, bus.cout_2,
                          bus.dut_sum, bus.dut_carry};
      end
   end

   assign bus.fail_valid = fail_valid_q;
   assign bus.fail_index = fail_index_q;
   assign bus.fail_data  = fail_data_q;
`else
   logic unused_s;
   assign unused_s = start_run_s;
`endif

endmodule
